score_event_arbiter: RTL and testbench
======================================

// Module: score_event_arbiter
// PURPOSE
//  Collects single-cycle scoring events (diamond, money bag, goblin) from game logic and
//  serialises them onto the 2-bit unit bus of the score accumulator, one code per cycle.
//  Buffers bursts and simultaneous events in per-source pending counters so no credit is
//  lost. Arbitrates fairly between sources. Sits between the game/collision logic and the
//  score accumulator.
// PARAMETERS
//  CNT_W   3   width of each per-source pending counter; saturates at 2**CNT_W-1
// PORTS
//  clk          in   1        system clock, all state on rising edge
//  rst          in   1        asynchronous, active-low reset
//  clear        in   1        sync flush of all pending credit (new level / game over)
//  pause        in   1        level: hold issue; events still counted
//  diamond_evt  in   1        one-cycle pulse, diamond collected (code 2'b01)
//  bag_evt      in   1        one-cycle pulse, money bag collected (code 2'b10)
//  goblin_evt   in   1        one-cycle pulse, goblin killed (code 2'b11)
//  unit         out  2        to score accumulator; 2'b00 = no credit this cycle
//  busy         out  1        any pending counter non-zero
//  pending      out  CNT_W+2  sum of the three pending counters
//  ovf          out  1        sticky: an event was dropped at saturation
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, counters=0, unit=2'b00, busy=0, pending=0, ovf=0,
//    rr pointer=goblin (first search starts at diamond).
//  - Sources indexed 0=diamond, 1=bag, 2=goblin. Event high in cycle 0 is counted at
//    edge 1. Earliest grant: unit driven from edge 2 (registered). 2-cycle latency.
//  - unit is registered and valid for exactly one cycle per grant. At most one grant per
//    cycle. Grant decrements that source's counter on the same edge unit is loaded.
//  - FSM:
//    IDLE: unit=00. If clear -> FLUSH. Elif any counter>0 and !pause -> ISSUE.
//    ISSUE: each cycle, grant the first non-zero source after the rr pointer (wrapping
//      0->1->2->0). Load its code and update the pointer. Go to IDLE when all counters
//      would be 0 after this grant, or pause=1 (no grant issued that cycle, unit=00).
//      clear -> FLUSH.
//    FLUSH: one cycle. unit=00, counters=0, events in this cycle ignored, ovf cleared.
//      -> IDLE.
//  - Same source event + grant on same edge: counter unchanged.
//  - Counter at max and event arrives with no grant: event dropped, ovf<=1.
//  - clear has priority over events, pause and grants. pause has priority over grants.
//  - busy/pending are combinational from the counters. The pending sum is zero-extended.
//  - Mid-operation reset: immediate return to reset values. Partial credit is discarded.
// CONFIGURATION
//  SCORE_ARB_FIXED_PRIO_EN defined: fixed priority goblin > bag > diamond. rr pointer is
//    unused and unsynthesised.
//  Undefined (default): round-robin as above. Each source is starved at most 2 grants.
// TESTING
//  - Single diamond_evt pulse at cycle 0 -> unit=01 in cycle 2 only, busy 1 in cycle 1 only.
//  - diamond, bag and goblin pulsed together -> unit=01,10,11 on consecutive cycles
//    (round-robin). With SCORE_ARB_FIXED_PRIO_EN: 11,10,01.
//  - goblin_evt held 10 cycles with pause=1, CNT_W=3 -> counter=7, ovf=1. Release pause ->
//    seven cycles of unit=11, then 00, busy=0.
//  - bag_evt every cycle while issuing bag grants -> counter steady at 1, unit=10 each
//    cycle, ovf=0.
//  - clear asserted with pending=5 -> next cycle unit=00, pending=0, ovf=0. Event on the
//    clear cycle not counted.
//  - rst low mid-burst -> outputs 0 asynchronously. After release, first grant needs a
//    new event.

Source files
------------

// File: rtl/score_event_arbiter.sv
// Purpose : serialise diamond/bag/goblin scoring pulses onto the 2-bit score unit bus,
//           buffering bursts in saturating per-source pending counters.
// Latency : event in cycle 0 is counted at edge 1; earliest unit code is driven from edge 2.
// Backpressure: pause holds issue (events still counted); counter overflow drops the
//           event and sets sticky ovf; clear flushes all pending credit.
//
// Ports:
//   clk, rst (async active-low), clear (sync flush), pause (hold issue),
//   diamond_evt / bag_evt / goblin_evt (one-cycle pulses, codes 01 / 10 / 11),
//   unit (registered code, 00 = no credit), busy (any credit pending),
//   pending (sum of counters, CNT_W+2 bits), ovf (sticky drop flag).
//
// Build option: define SCORE_ARB_FIXED_PRIO_EN for fixed priority goblin > bag > diamond;
// otherwise sources are served round-robin (diamond -> bag -> goblin -> diamond).

module score_event_arbiter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             pause,
    input  logic             diamond_evt,
    input  logic             bag_evt,
    input  logic             goblin_evt,
    output logic [1:0]       unit,
    output logic             busy,
    output logic [CNT_W+1:0] pending,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;

    // Source index 0 = diamond, 1 = bag, 2 = goblin.
    logic [2:0][CNT_W-1:0] cnt;
    logic [2:0][CNT_W-1:0] cnt_nxt;
    logic [2:0]            evt;
    logic [2:0]            nz;
    logic [2:0]            drop;
    logic [2:0]            gnt;
    logic                  ovf_nxt;
    logic                  flush;

    logic                  pick_vld;
    logic [1:0]            pick_idx;
    logic                  grant_vld;
    logic [1:0]            unit_nxt;

    assign evt = {goblin_evt, bag_evt, diamond_evt};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nz[i] = (cnt[i] != '0);
        end
    end

    //------------------------------------------------------------------
    // Source selection among non-zero counters
    //------------------------------------------------------------------
`ifdef SCORE_ARB_FIXED_PRIO_EN
    always_comb begin
        pick_vld = |nz;
        if (nz[2]) begin
            pick_idx = 2'd2;
        end else if (nz[1]) begin
            pick_idx = 2'd1;
        end else begin
            pick_idx = 2'd0;
        end
    end
`else
    // rr holds the most recently granted source; the search starts just after it.
    logic [1:0] rr;

    function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    always_comb begin
        logic [1:0] cand;
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        cand     = rr;
        for (int k = 0; k < 3; k++) begin
            cand = wrap_inc(cand);
            if (!pick_vld && nz[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr <= 2'd2;
        end else if (grant_vld) begin
            rr <= pick_idx;
        end
    end
`endif

    //------------------------------------------------------------------
    // Grant decision. IDLE grants directly so a fresh credit reaches the
    // bus one cycle after it is counted; clear beats pause beats grant.
    //------------------------------------------------------------------
    assign flush = clear || (state == FLUSH);

    always_comb begin
        grant_vld = 1'b0;
        if ((state == IDLE) || (state == ISSUE)) begin
            grant_vld = !clear && !pause && pick_vld;
        end
    end

    assign gnt      = grant_vld ? (3'b001 << pick_idx) : 3'b000;
    assign unit_nxt = grant_vld ? (pick_idx + 2'd1) : 2'b00;

    //------------------------------------------------------------------
    // Pending counters: event and grant on the same edge cancel, an event
    // into a saturated counter without a grant is dropped.
    //------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_nxt[i] = cnt[i];
            drop[i]    = 1'b0;
            if (flush) begin
                cnt_nxt[i] = '0;
            end else if (evt[i] && !gnt[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    drop[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end
            end else if (gnt[i] && !evt[i]) begin
                cnt_nxt[i] = cnt[i] - CNT_ONE;
            end
        end
    end

    assign ovf_nxt = flush ? 1'b0 : (ovf | (|drop));

    //------------------------------------------------------------------
    // FSM
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ISSUE: begin
                if (clear) begin
                    state_nxt = FLUSH;
                end else if (pause) begin
                    state_nxt = IDLE;
                end else if (grant_vld && (cnt_nxt != '0)) begin
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                // A clear held across the flush cycle keeps flushing.
                state_nxt = clear ? FLUSH : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            unit <= 2'b00;
            ovf  <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            unit <= unit_nxt;
            ovf  <= ovf_nxt;
        end
    end

    assign busy    = |nz;
    assign pending = {2'b00, cnt[0]} + {2'b00, cnt[1]} + {2'b00, cnt[2]};

endmodule

// File: tb/tb_score_event_arbiter.sv
// Purpose : directed self-check of score_event_arbiter against hand-computed vectors.
// Latency : cycle k is the interval after rising edge k; outputs sampled 1 ns after the edge.
// Backpressure: exercises pause, saturation/overflow, clear and async reset.

module tb_score_event_arbiter;

    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             pause;
    logic             diamond_evt;
    logic             bag_evt;
    logic             goblin_evt;
    logic [1:0]       unit;
    logic             busy;
    logic [CNT_W+1:0] pending;
    logic             ovf;

    int vectors;
    int miscompares;

    score_event_arbiter #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .pause       (pause),
        .diamond_evt (diamond_evt),
        .bag_evt     (bag_evt),
        .goblin_evt  (goblin_evt),
        .unit        (unit),
        .busy        (busy),
        .pending     (pending),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        clear       = 1'b0;
        pause       = 1'b0;
        diamond_evt = 1'b0;
        bag_evt     = 1'b0;
        goblin_evt  = 1'b0;

        // Reset state
        repeat (2) tick;
        chk("rst_unit", {30'd0, unit}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pending", {27'd0, pending}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b1;

        // Three simultaneous events
        tick;
        diamond_evt = 1'b1; bag_evt = 1'b1; goblin_evt = 1'b1;
        tick;
        diamond_evt = 1'b0; bag_evt = 1'b0; goblin_evt = 1'b0;
        chk("tri_c1_pending", {27'd0, pending}, 32'd3);
        chk("tri_c1_unit", {30'd0, unit}, 32'd0);
        tick;
`ifdef SCORE_ARB_FIXED_PRIO_EN
        chk("tri_c2_unit", {30'd0, unit}, 32'd3);
        tick;
        chk("tri_c3_unit", {30'd0, unit}, 32'd2);
        tick;
        chk("tri_c4_unit", {30'd0, unit}, 32'd1);
`else
        chk("tri_c2_unit", {30'd0, unit}, 32'd1);
        tick;
        chk("tri_c3_unit", {30'd0, unit}, 32'd2);
        tick;
        chk("tri_c4_unit", {30'd0, unit}, 32'd3);
`endif
        chk("tri_c4_busy", {31'd0, busy}, 32'd0);
        tick;
        chk("tri_c5_unit", {30'd0, unit}, 32'd0);

        // Single diamond pulse
        tick;
        diamond_evt = 1'b1;
        tick;
        diamond_evt = 1'b0;
        chk("dia_c1_busy", {31'd0, busy}, 32'd1);
        chk("dia_c1_unit", {30'd0, unit}, 32'd0);
        tick;
        chk("dia_c2_unit", {30'd0, unit}, 32'd1);
        chk("dia_c2_busy", {31'd0, busy}, 32'd0);
        tick;
        chk("dia_c3_unit", {30'd0, unit}, 32'd0);

        // Goblin held 10 cycles under pause: saturate at 7, then overflow
        tick;
        pause = 1'b1; goblin_evt = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (i == 7) begin
                chk("sat_c7_pending", {27'd0, pending}, 32'd7);
                chk("sat_c7_ovf", {31'd0, ovf}, 32'd0);
            end
            if (i == 8) chk("sat_c8_ovf", {31'd0, ovf}, 32'd1);
            if (i == 10) goblin_evt = 1'b0;
        end
        chk("sat_c10_pending", {27'd0, pending}, 32'd7);
        chk("sat_c10_unit", {30'd0, unit}, 32'd0);
        chk("sat_c10_busy", {31'd0, busy}, 32'd1);
        pause = 1'b0;
        for (int k = 11; k <= 17; k++) begin
            tick;
            chk("drain_unit", {30'd0, unit}, 32'd3);
            chk("drain_pending", {27'd0, pending}, 32'(17 - k));
        end
        tick;
        chk("drain_end_unit", {30'd0, unit}, 32'd0);
        chk("drain_end_busy", {31'd0, busy}, 32'd0);
        chk("drain_end_ovf", {31'd0, ovf}, 32'd1);

        // Clear with pending = 5 (2 diamond, 2 bag, 1 goblin)
        tick;
        pause = 1'b1; diamond_evt = 1'b1; bag_evt = 1'b1; goblin_evt = 1'b1;
        tick;
        goblin_evt = 1'b0;
        tick;
        diamond_evt = 1'b0; bag_evt = 1'b0;
        chk("clr_pre_pending", {27'd0, pending}, 32'd5);
        chk("clr_pre_ovf", {31'd0, ovf}, 32'd1);
        clear = 1'b1; diamond_evt = 1'b1;
        tick;
        clear = 1'b0; diamond_evt = 1'b0; bag_evt = 1'b1;
        chk("clr_unit", {30'd0, unit}, 32'd0);
        chk("clr_pending", {27'd0, pending}, 32'd0);
        chk("clr_ovf", {31'd0, ovf}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        tick;
        bag_evt = 1'b0;
        chk("flush_pending", {27'd0, pending}, 32'd0);
        pause = 1'b0;
        tick;
        chk("post_flush_unit", {30'd0, unit}, 32'd0);
        chk("post_flush_busy", {31'd0, busy}, 32'd0);

        // Bag every cycle while bag grants are issued
        tick;
        bag_evt = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick;
            chk("bag_unit", {30'd0, unit}, (k >= 2) ? 32'd2 : 32'd0);
            chk("bag_pending", {27'd0, pending}, (k <= 6) ? 32'd1 : 32'd0);
            if (k == 6) bag_evt = 1'b0;
        end
        tick;
        chk("bag_end_unit", {30'd0, unit}, 32'd0);
        chk("bag_end_ovf", {31'd0, ovf}, 32'd0);

        // Reset mid-burst
        tick;
        diamond_evt = 1'b1; bag_evt = 1'b1; goblin_evt = 1'b1;
        tick;
        tick;
        diamond_evt = 1'b0; bag_evt = 1'b0; goblin_evt = 1'b0;
        chk("burst_unit", {30'd0, unit}, 32'd3);
        chk("burst_pending", {27'd0, pending}, 32'd5);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_unit", {30'd0, unit}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_pending", {27'd0, pending}, 32'd0);
        chk("arst_ovf", {31'd0, ovf}, 32'd0);
        tick;
        rst = 1'b1;
        repeat (3) begin
            tick;
            chk("idle_after_rst_unit", {30'd0, unit}, 32'd0);
        end
        goblin_evt = 1'b1;
        tick;
        goblin_evt = 1'b0;
        chk("rerun_c1_unit", {30'd0, unit}, 32'd0);
        tick;
        chk("rerun_c2_unit", {30'd0, unit}, 32'd3);
        chk("rerun_c2_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
